// File: rtl/segre_bypass_tracker.sv
// ============================================================================
// segre_bypass_tracker
// ----------------------------------------------------------------------------
// In-flight destination tracker for NUM_PIPES execution pipelines of differing
// latency. It sits between decode and the pipeline wrapper. Each pipe keeps a
// shift register of {valid, waddr} slots, one per stage. From these slots the
// block produces:
//   - operand bypass selects and bypass data,
//   - RAW, WAW and target-pipe-stall hazards,
//   - per-pipe freezing on stall,
//   - squashing of younger work on flush.
//
// Ports (segre_bypass_tracker):
//   clk_i, rst_i            clock, synchronous active-high reset
//   issue_valid_i           decode presents an instruction
//   issue_pipe_i            target pipeline index
//   issue_we_i              instruction writes rd
//   issue_waddr_i           rd
//   src_a_i, src_b_i        rs1 / rs2
//   issue_ready_o           instruction accepted this cycle
//   hazard_o                decode must hold (RAW / WAW / stalled target)
//   byp_a_o, byp_b_o        one-hot select: bit0 = RF, bit p+1 = pipe p
//   byp_data_a_o, _b_o      bypassed operand (0 when RF is selected)
//   pipe_stall_i            pipe p frozen this cycle
//   wb_we_i                 pipe p final-stage write enable
//   wb_waddr_i, wb_data_i   pipe p final-stage rd / result (flat, pipe0 in LSBs)
//   flush_i                 squash younger in-flight work
//   inflight_cnt_o          registered count of valid tracked entries
//
// segre_bypass_pipe holds the slots of one pipe. It is padded to MAXL slots so
// the top can gather every pipe into one uniform array. Slots at LAT and above
// are tied invalid.
// ============================================================================

module segre_bypass_pipe #(
    parameter int LAT      = 1,
    parameter int MAXL     = 1,
    parameter int REG_SIZE = 5
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               stall_i,
    input  logic                               flush_i,
    input  logic                               push_i,
    input  logic                               push_we_i,
    input  logic [REG_SIZE-1:0]                push_waddr_i,
    input  logic [REG_SIZE-1:0]                src_a_i,
    input  logic [REG_SIZE-1:0]                src_b_i,
    input  logic                               rd_we_i,
    input  logic [REG_SIZE-1:0]                rd_i,
    output logic                               raw_a_o,
    output logic                               raw_b_o,
    output logic                               fin_a_o,
    output logic                               fin_b_o,
    output logic                               waw_o,
    output logic [MAXL-1:0]                    valid_o,
    output logic [MAXL-1:0][REG_SIZE-1:0]      waddr_o,
    output logic [7:0]                         cnt_o
);

    logic [MAXL-1:0]               valid_q, valid_d;
    logic [MAXL-1:0][REG_SIZE-1:0] waddr_q, waddr_d;

    always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        if (!stall_i) begin
            for (int i = MAXL-1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                waddr_d[i] = waddr_q[i-1];
            end
            // An entry that never writes (or writes x0) is never tracked.
            valid_d[0] = push_i && push_we_i && (push_waddr_i != '0);
            waddr_d[0] = push_waddr_i;
        end
        // Flush clears every non-final slot. A final slot survives only
        // when its pipe is frozen. Otherwise it retires at this edge anyway.
        if (flush_i) begin
            for (int i = 0; i < MAXL; i++) begin
                if (i != LAT-1 || !stall_i) valid_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < MAXL; i++) begin
            if (i >= LAT) begin
                valid_d[i] = 1'b0;
                waddr_d[i] = '0;
            end
        end
    end

    always_comb begin
        raw_a_o = 1'b0;
        raw_b_o = 1'b0;
        fin_a_o = 1'b0;
        fin_b_o = 1'b0;
        waw_o   = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (valid_q[i] && waddr_q[i] == src_a_i && src_a_i != '0) begin
                if (i == LAT-1) fin_a_o = 1'b1;
                else            raw_a_o = 1'b1;
            end
            if (valid_q[i] && waddr_q[i] == src_b_i && src_b_i != '0) begin
                if (i == LAT-1) fin_b_o = 1'b1;
                else            raw_b_o = 1'b1;
            end
            // A final slot in a moving pipe retires at this edge. The new
            // writer may therefore take the same rd in the same cycle.
            if (rd_we_i && valid_q[i] && waddr_q[i] == rd_i &&
                !(i == LAT-1 && !stall_i))
                waw_o = 1'b1;
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < MAXL; i++) cnt_o = cnt_o + 8'(valid_d[i]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            waddr_q <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
        end
    end

    assign valid_o = valid_q;
    assign waddr_o = waddr_q;

endmodule

module segre_bypass_tracker #(
    parameter int                         NUM_PIPES = 3,
    parameter int                         LAT_W     = 4,
    parameter logic [NUM_PIPES*LAT_W-1:0] PIPE_LAT  = {4'd5, 4'd3, 4'd1},
    parameter int                         REG_SIZE  = 5,
    parameter int                         WORD_SIZE = 32,
    parameter int                         PIPE_W    = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           issue_valid_i,
    input  logic [PIPE_W-1:0]              issue_pipe_i,
    input  logic                           issue_we_i,
    input  logic [REG_SIZE-1:0]            issue_waddr_i,
    input  logic [REG_SIZE-1:0]            src_a_i,
    input  logic [REG_SIZE-1:0]            src_b_i,
    output logic                           issue_ready_o,
    output logic                           hazard_o,
    output logic [NUM_PIPES:0]             byp_a_o,
    output logic [NUM_PIPES:0]             byp_b_o,
    output logic [WORD_SIZE-1:0]           byp_data_a_o,
    output logic [WORD_SIZE-1:0]           byp_data_b_o,
    input  logic [NUM_PIPES-1:0]           pipe_stall_i,
    input  logic [NUM_PIPES-1:0]           wb_we_i,
    input  logic [NUM_PIPES*REG_SIZE-1:0]  wb_waddr_i,
    input  logic [NUM_PIPES*WORD_SIZE-1:0] wb_data_i,
    input  logic                           flush_i,
    output logic [7:0]                     inflight_cnt_o
);

    function automatic int max_lat();
        int m;
        m = 1;
        for (int p = 0; p < NUM_PIPES; p++)
            if (int'(PIPE_LAT[p*LAT_W +: LAT_W]) > m) m = int'(PIPE_LAT[p*LAT_W +: LAT_W]);
        return m;
    endfunction

    localparam int MAXL = max_lat();

    logic [NUM_PIPES-1:0]                          raw_a, raw_b, fin_a, fin_b, waw, push;
    logic [NUM_PIPES-1:0][MAXL-1:0]                slot_v;
    logic [NUM_PIPES-1:0][MAXL-1:0][REG_SIZE-1:0]  slot_a;
    logic [NUM_PIPES-1:0][7:0]                     pcnt;
    logic                                          tgt_stall, hazard, ready;
    logic [7:0]                                    cnt_d, cnt_q;
    logic [NUM_PIPES-1:0]                          sel_a, sel_b;

    // An issue_pipe_i value that names no pipe is treated as stalled, so the
    // instruction is never accepted.
    always_comb begin
        tgt_stall = 1'b1;
        for (int p = 0; p < NUM_PIPES; p++)
            if (issue_pipe_i == PIPE_W'(p)) tgt_stall = pipe_stall_i[p];
    end

    assign hazard = issue_valid_i && ((|raw_a) || (|raw_b) || (|waw) || tgt_stall);
    assign ready  = issue_valid_i && !hazard && !tgt_stall && !flush_i;

    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        localparam int LAT = int'(PIPE_LAT[p*LAT_W +: LAT_W]);

        assign push[p] = ready && (issue_pipe_i == PIPE_W'(p));

        segre_bypass_pipe #(
            .LAT      (LAT),
            .MAXL     (MAXL),
            .REG_SIZE (REG_SIZE)
        ) u_pipe (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .stall_i      (pipe_stall_i[p]),
            .flush_i      (flush_i),
            .push_i       (push[p]),
            .push_we_i    (issue_we_i),
            .push_waddr_i (issue_waddr_i),
            .src_a_i      (src_a_i),
            .src_b_i      (src_b_i),
            .rd_we_i      (issue_valid_i && issue_we_i),
            .rd_i         (issue_waddr_i),
            .raw_a_o      (raw_a[p]),
            .raw_b_o      (raw_b[p]),
            .fin_a_o      (fin_a[p]),
            .fin_b_o      (fin_b[p]),
            .waw_o        (waw[p]),
            .valid_o      (slot_v[p]),
            .waddr_o      (slot_a[p]),
            .cnt_o        (pcnt[p])
        );

        a_wb_match: assert property (@(posedge clk_i) disable iff (rst_i)
            wb_we_i[p] |-> (slot_v[p][LAT-1] &&
                            slot_a[p][LAT-1] == wb_waddr_i[p*REG_SIZE +: REG_SIZE]));
    end

    // WAW blocking guarantees at most one pipe matches a source. The data
    // may therefore be OR-combined without a priority chain.
    always_comb begin
        sel_a        = fin_a & wb_we_i;
        sel_b        = fin_b & wb_we_i;
        byp_data_a_o = '0;
        byp_data_b_o = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            if (sel_a[p]) byp_data_a_o = byp_data_a_o | wb_data_i[p*WORD_SIZE +: WORD_SIZE];
            if (sel_b[p]) byp_data_b_o = byp_data_b_o | wb_data_i[p*WORD_SIZE +: WORD_SIZE];
        end
        byp_a_o = {sel_a, ~|sel_a};
        byp_b_o = {sel_b, ~|sel_b};
    end

    always_comb begin
        cnt_d = '0;
        for (int p = 0; p < NUM_PIPES; p++) cnt_d = cnt_d + pcnt[p];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign issue_ready_o  = ready;
    assign hazard_o       = hazard;
    assign inflight_cnt_o = cnt_q;

    logic dup;
    always_comb begin
        dup = 1'b0;
        for (int p = 0; p < NUM_PIPES; p++)
            for (int i = 0; i < MAXL; i++)
                for (int q = 0; q < NUM_PIPES; q++)
                    for (int j = 0; j < MAXL; j++)
                        if ((p*MAXL + i) < (q*MAXL + j) && slot_v[p][i] && slot_v[q][j] &&
                            slot_a[p][i] == slot_a[q][j])
                            dup = 1'b1;
    end

    a_no_dup: assert property (@(posedge clk_i) disable iff (rst_i) !dup);

endmodule

// File: tb/tb_segre_bypass_tracker.sv
// Directed bench for segre_bypass_tracker with default parameters.
// Pipe latencies: pipe0 = 1, pipe1 = 3, pipe2 = 5.
// Timing: inputs change 1ns after a rising edge; outputs are sampled on the
// falling edge.
module tb_segre_bypass_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [1:0]  issue_pipe;
    logic        issue_we;
    logic [4:0]  issue_waddr, src_a, src_b;
    logic        ready, hazard;
    logic [3:0]  byp_a, byp_b;
    logic [31:0] bda, bdb;
    logic [2:0]  pipe_stall, wb_we;
    logic [14:0] wb_waddr;
    logic [95:0] wb_data;
    logic        flush;
    logic [7:0]  cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    segre_bypass_tracker dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .issue_valid_i  (issue_valid),
        .issue_pipe_i   (issue_pipe),
        .issue_we_i     (issue_we),
        .issue_waddr_i  (issue_waddr),
        .src_a_i        (src_a),
        .src_b_i        (src_b),
        .issue_ready_o  (ready),
        .hazard_o       (hazard),
        .byp_a_o        (byp_a),
        .byp_b_o        (byp_b),
        .byp_data_a_o   (bda),
        .byp_data_b_o   (bdb),
        .pipe_stall_i   (pipe_stall),
        .wb_we_i        (wb_we),
        .wb_waddr_i     (wb_waddr),
        .wb_data_i      (wb_data),
        .flush_i        (flush),
        .inflight_cnt_o (cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_pipe = 2'd0; issue_we = 1'b0; issue_waddr = 5'd0;
        src_a = 5'd0; src_b = 5'd0; pipe_stall = 3'b000; wb_we = 3'b000;
        wb_waddr = '0; wb_data = '0; flush = 1'b0;
    endtask

    task automatic iss(input int p, input logic we, input logic [4:0] rd,
                       input logic [4:0] a, input logic [4:0] b);
        issue_valid = 1'b1; issue_pipe = 2'(p); issue_we = we; issue_waddr = rd;
        src_a = a; src_b = b;
    endtask

    task automatic wb(input int p, input logic [4:0] rd, input logic [31:0] d);
        wb_we[p] = 1'b1;
        wb_waddr[p*5 +: 5] = rd;
        wb_data[p*32 +: 32] = d;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state
        smp();
        chk("rst_cnt", cnt, 0);
        chk("rst_haz", hazard, 0);
        chk("rst_byp_a", byp_a, 4'b0001);
        chk("rst_byp_b", byp_b, 4'b0001);
        chk("rst_data_a", bda, 0);

        // 2: pipe0 (L=1) issues x5, result bypassed next cycle
        nxt();
        iss(0, 1'b1, 5'd5, 5'd0, 5'd0);
        smp();
        chk("p0_issue_rdy", ready, 1);
        nxt();
        iss(1, 1'b0, 5'd0, 5'd5, 5'd0);
        wb(0, 5'd5, 32'hDEAD);
        smp();
        chk("p0_byp_a", byp_a, 4'b0010);
        chk("p0_data_a", bda, 32'hDEAD);
        chk("p0_haz", hazard, 0);
        chk("p0_cnt", cnt, 1);
        nxt();
        smp();
        chk("p0_cnt_after", cnt, 0);

        // 3: pipe2 (L=5) issues x7; RAW for 4 cycles, then bypass
        nxt();
        iss(2, 1'b1, 5'd7, 5'd0, 5'd0);
        smp();
        chk("p2_issue_rdy", ready, 1);
        for (int k = 1; k <= 4; k++) begin
            nxt();
            iss(0, 1'b0, 5'd0, 5'd0, 5'd7);
            smp();
            chk($sformatf("p2_raw_haz%0d", k), hazard, 1);
            chk($sformatf("p2_raw_rdy%0d", k), ready, 0);
        end
        nxt();
        iss(0, 1'b0, 5'd0, 5'd0, 5'd7);
        wb(2, 5'd7, 32'h1234_5678);
        smp();
        chk("p2_byp_haz", hazard, 0);
        chk("p2_byp_b", byp_b, 4'b1000);
        chk("p2_data_b", bdb, 32'h1234_5678);
        chk("p2_byp_a_rf", byp_a, 4'b0001);
        nxt();
        smp();
        chk("p2_cnt_after", cnt, 0);

        // 4: pipe1 (L=3) issues x9, then stalls for 3 cycles
        nxt();
        iss(1, 1'b1, 5'd9, 5'd0, 5'd0);
        smp();
        chk("p1_issue_rdy", ready, 1);
        for (int k = 1; k <= 3; k++) begin
            nxt();
            pipe_stall = 3'b010;
            iss(1, 1'b0, 5'd0, 5'd0, 5'd0);
            smp();
            chk($sformatf("p1_stall_haz%0d", k), hazard, 1);
            chk($sformatf("p1_stall_rdy%0d", k), ready, 0);
        end
        for (int k = 4; k <= 5; k++) begin
            nxt();
            iss(0, 1'b0, 5'd0, 5'd9, 5'd0);
            smp();
            chk($sformatf("p1_raw_haz%0d", k), hazard, 1);
        end
        nxt();
        iss(0, 1'b0, 5'd0, 5'd9, 5'd0);
        wb(1, 5'd9, 32'hAAAA_5555);
        smp();
        chk("p1_byp_haz", hazard, 0);
        chk("p1_byp_a", byp_a, 4'b0100);
        chk("p1_data_a", bda, 32'hAAAA_5555);
        nxt();
        smp();
        chk("p1_cnt_after", cnt, 0);

        // 5: WAW between x3 on pipe2 and x3 on pipe0
        nxt();
        iss(2, 1'b1, 5'd3, 5'd0, 5'd0);
        smp();
        chk("waw_first_rdy", ready, 1);
        for (int k = 1; k <= 4; k++) begin
            nxt();
            iss(0, 1'b1, 5'd3, 5'd0, 5'd0);
            smp();
            chk($sformatf("waw_haz%0d", k), hazard, 1);
        end
        nxt();
        iss(0, 1'b1, 5'd3, 5'd0, 5'd0);
        wb(2, 5'd3, 32'h3333);
        smp();
        chk("waw_retire_haz", hazard, 0);
        chk("waw_retire_rdy", ready, 1);
        nxt();
        wb(0, 5'd3, 32'h4444);
        smp();
        chk("waw_cnt", cnt, 1);
        nxt();
        smp();
        chk("waw_cnt_after", cnt, 0);

        // 6: flush with pipe1 final slot frozen and two pipe2 entries
        nxt();
        iss(1, 1'b1, 5'd10, 5'd0, 5'd0);
        nxt();
        iss(2, 1'b1, 5'd11, 5'd0, 5'd0);
        nxt();
        iss(2, 1'b1, 5'd12, 5'd0, 5'd0);
        nxt();
        flush = 1'b1;
        pipe_stall = 3'b010;
        iss(0, 1'b1, 5'd13, 5'd0, 5'd0);
        smp();
        chk("fl_cnt_before", cnt, 3);
        chk("fl_drop_rdy", ready, 0);
        nxt();
        pipe_stall = 3'b010;
        iss(0, 1'b0, 5'd0, 5'd11, 5'd13);
        smp();
        chk("fl_cnt_after", cnt, 1);
        chk("fl_cleared_haz", hazard, 0);
        chk("fl_cleared_byp", byp_a, 4'b0001);
        nxt();
        iss(0, 1'b0, 5'd0, 5'd10, 5'd0);
        wb(1, 5'd10, 32'hBEEF);
        smp();
        chk("fl_kept_byp", byp_a, 4'b0100);
        chk("fl_kept_data", bda, 32'hBEEF);
        nxt();
        smp();
        chk("fl_cnt_end", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
